// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: default 640x480@60
// geometry, the delay-line element type and a geometry helper.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Coordinates travel down the delay line at a fixed width; the top
    // module narrows them back to its own CW.
    localparam int VGA_COORD_W = 16;

    typedef logic [VGA_COORD_W-1:0] vga_coord_t;

    typedef struct packed {
        logic       h_sync;
        logic       v_sync;
        logic       active;
        vga_coord_t x;
        vga_coord_t y;
        logic       line_start;
        logic       frame_start;
    } vga_sig_t;

    function automatic int vga_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic bit vga_fits(input int total, input int cw);
        return (cw >= 1) && (cw <= 31) && ((total - 1) < (1 << cw));
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DELAY stages with a synchronous reset value.
// DELAY = 0 degenerates to a wire from d to q.
module vga_delay_line #(
    parameter int  DELAY = 1,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  T     rst_val,
    input  T     d,
    output T     q
);

    generate
        if (DELAY == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            T chain [DELAY+1];

            assign chain[0] = d;

            for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
                T stage_q;
                T stage_d;

                always_comb begin
                    stage_d = stage_q;
                    if (en) begin
                        stage_d = chain[gi];
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        stage_q <= rst_val;
                    end else begin
                        stage_q <= stage_d;
                    end
                end

                assign chain[gi+1] = stage_q;
            end

            assign q = chain[DELAY];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, combinational decode
// and a pix_en-gated output delay line. Define VGA_TIMING_FRAME_CNT_EN to add
// the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int DELAY    = 1,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic H_ASSERT = (H_POL != 0);
    localparam logic V_ASSERT = (V_POL != 0);

    localparam vga_sig_t IDLE_SIG = '{
        h_sync:  ~H_ASSERT,
        v_sync:  ~V_ASSERT,
        default: '0
    };

    generate
        if (!vga_fits(H_TOTAL, CW)) begin : g_chk_h_total
            $error("vga_timing_gen: CW too narrow for H_TOTAL-1");
        end
        if (!vga_fits(V_TOTAL, CW)) begin : g_chk_v_total
            $error("vga_timing_gen: CW too narrow for V_TOTAL-1");
        end
        if (CW > VGA_COORD_W) begin : g_chk_cw
            $error("vga_timing_gen: CW exceeds the delay-line coordinate width");
        end
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || H_ACTIVE < 1) begin : g_chk_h_widths
            $error("vga_timing_gen: horizontal region widths must be at least 1");
        end
        if (V_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1) begin : g_chk_v_widths
            $error("vga_timing_gen: vertical region widths must be at least 1");
        end
        if (DELAY < 0 || DELAY > 8) begin : g_chk_delay
            $error("vga_timing_gen: DELAY must be in 0..8");
        end
    endgenerate

    logic [CW-1:0] h_cnt_q;
    logic [CW-1:0] h_cnt_d;
    logic [CW-1:0] v_cnt_q;
    logic [CW-1:0] v_cnt_d;
    logic          h_wrap;
    logic          v_wrap;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Decode of the current count; everything downstream sees it DELAY
    // enabled edges later.
    logic     h_in_sync;
    logic     v_in_sync;
    logic     in_active;
    vga_sig_t dec_sig;

    always_comb begin
        h_in_sync = (h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END);
        v_in_sync = (v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END);
        in_active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);

        dec_sig             = '0;
        dec_sig.h_sync      = h_in_sync ? H_ASSERT : ~H_ASSERT;
        dec_sig.v_sync      = v_in_sync ? V_ASSERT : ~V_ASSERT;
        dec_sig.active      = in_active;
        dec_sig.x           = in_active ? vga_coord_t'(h_cnt_q) : '0;
        dec_sig.y           = in_active ? vga_coord_t'(v_cnt_q) : '0;
        dec_sig.line_start  = (h_cnt_q == '0);
        dec_sig.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    vga_sig_t out_sig;

    vga_delay_line #(
        .DELAY (DELAY),
        .T     (vga_sig_t)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .en      (pix_en),
        .rst_val (IDLE_SIG),
        .d       (dec_sig),
        .q       (out_sig)
    );

    assign h_sync      = out_sig.h_sync;
    assign v_sync      = out_sig.v_sync;
    assign active      = out_sig.active;
    assign x           = out_sig.x[CW-1:0];
    assign y           = out_sig.y[CW-1:0];
    assign line_start  = out_sig.line_start;
    assign frame_start = out_sig.frame_start;

    // Coordinate bits above CW are always zero; fold them into a sink.
    logic unused_coord_bits;
    assign unused_coord_bits = ^{out_sig.x, out_sig.y};

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counted at the counter stage, so it leads the delayed frame_start.
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pix_en && h_wrap && v_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_wrap_bits;
    assign unused_wrap_bits = h_wrap & v_wrap;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 sync block. It drives `h_sync`/`v_sync`, the active-video flag and pixel coordinates to the pixel-render logic and the VGA pins. Mode geometry, sync polarity and a pixel-rate enable are configurable. A configurable output delay line keeps sync aligned with the latency of the downstream pixel pipeline.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 0: asserted level of `h_sync` (0 = active-low).
- `V_POL`, 0: asserted level of `v_sync` (0 = active-low).
- `DELAY`, 1: number of output register stages (0..8).
- `CW`, 10: counter and coordinate width. Must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous reset, active-high.
- `pix_en` in 1: pixel-rate enable. Counters and the delay line advance only on cycles where it is high.
- `h_sync` out 1: horizontal sync, polarity set by `H_POL`.
- `v_sync` out 1: vertical sync, polarity set by `V_POL`.
- `active` out 1: high inside the visible region.
- `x` out CW: pixel column. Equals h_cnt when active, 0 otherwise.
- `y` out CW: pixel row. Equals v_cnt when active, 0 otherwise.
- `line_start` out 1: high for the pixel where h_cnt == 0.
- `frame_start` out 1: high for the pixel where h_cnt == 0 and v_cnt == 0.

## Operation
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800); V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
- Region order on both axes is active, then front porch, then sync, then back porch.
- Horizontal sync is asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. Vertical sync uses the same rule on v_cnt.
- `active` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Counter update, on `pix_en` only:
  - h_cnt increments from 0 to H_TOTAL-1, then wraps to 0.
  - v_cnt increments only on the h wrap, and wraps from V_TOTAL-1 to 0.
  - Simultaneous h and v wrap sends both counters to 0 on the same edge.
- No state machine. The two counters are the entire timing state.
- Decode is combinational from the counter registers. It is then passed through `DELAY` register stages, each loaded only on `pix_en`.
- `pix_en` held low freezes the counters and every output.
- `reset` takes priority over `pix_en`. Reset mid-frame restarts at (0,0) on the next edge.
- Reset values (DELAY ≥ 1):
  - h_cnt = v_cnt = 0.
  - Every delay stage is set to: `h_sync` = !H_POL, `v_sync` = !V_POL, `active` 0, `x` 0, `y` 0, `line_start` 0, `frame_start` 0.
- Reset values (DELAY = 0): outputs are the decode of count (0,0), i.e. `active` = 1, `line_start` = 1, `frame_start` = 1, syncs deasserted.

## Timing
- Latency is exactly DELAY `pix_en`-qualified edges from counter state to outputs. All outputs share that latency, so they stay mutually aligned.
- First count advance happens on the first `pix_en` edge after `reset` deasserts.
- With `pix_en` tied to 1 and 640x480 defaults:
  - Line period is 800 clocks; frame period is 420000 clocks.
  - `h_sync` is low for 96 clocks per line.
  - `v_sync` is low for 1600 clocks per frame.
- `line_start` and `frame_start` are levels lasting one pixel period. Consumers qualify them with `pix_en`.

## Configuration
- Macro `VGA_TIMING_FRAME_CNT_EN`.
- Defined:
  - Adds output `frame_cnt` [15:0], reset value 0.
  - Increments on the `pix_en` edge where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1; wraps 65535 → 0.
  - It is not delayed: it changes on the same edge that `frame_start` enters the delay line.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `vga_pkg` holds:
  - Default 640x480@60 mode localparams.
  - A `vga_sig_t` packed struct {h_sync, v_sync, active, x, y, line_start, frame_start}, used as the delay-line element.
  - Function `vga_total()`, used for parameter checks.
- One sub-module, `vga_delay_line`:
  - Parameterised on DELAY and the element type.
  - Enable-gated shift register with a synchronous reset value input.
  - DELAY = 0 means a wire-through.
- Elaboration-time assertions: CW large enough for both totals; every porch and sync width ≥ 1.

## Test plan
- Defaults, `pix_en` = 1, DELAY = 1: after reset, `h_sync` falls 657 clocks after the first counting edge (656 + 1 stage), stays low 96 clocks, and repeats every 800 clocks.
- Same setup: `v_sync` low for exactly 1600 consecutive clocks. `frame_start` pulses every 420000 clocks. `active` is high for 640 × 480 clocks per frame.
- `pix_en` toggling 1/0: all periods double. Outputs hold unchanged across every `pix_en` = 0 cycle.
- DELAY = 3 vs DELAY = 0 run in parallel: outputs identical, shifted by 3 clocks.
- `reset` asserted at h = 400, v = 200: after release, `frame_start` arrives 1 edge later and `x`/`y` restart at 0.
- `H_POL` = `V_POL` = 1, `VGA_TIMING_FRAME_CNT_EN` defined: syncs are high-active and idle at 0. `frame_cnt` reads 3 after 3 full frames.
